phase_pair_meter: RTL and testbench
===================================

Name: phase_pair_meter

Overview:
Sits between the two LVDS digitizer outputs of the dual-receiver phase design and the hex-dump/UART reporting path. Measures, in clk cycles, the delay from a rising edge on channel 0 to the next rising edge on channel 1, and the channel-0 period. Accumulates 2^NAVG_LOG2 good measurements and presents the two sums through a valid/ready output register.

Parameters:
CW, 16, width of the per-measurement phase and period counters.
NAVG_LOG2, 4, log2 of the number of measurements summed per result (16).
TIMEOUT, 65535, period-counter limit in cycles; must be <= 2^CW-1.

Ports:
clk  in  1  system clock (48 MHz xtal).
rst  in  1  synchronous reset, active-high.
sig0  in  1  digitized channel 0; asynchronous to clk.
sig1  in  1  digitized channel 1; asynchronous to clk.
out_ready  in  1  consumer accepts the result.
out_valid  out  1  result registers hold an unconsumed result.
phase_sum  out  CW+NAVG_LOG2  sum of phase counts.
period_sum  out  CW+NAVG_LOG2  sum of period counts.
err_miss  out  1  one-cycle pulse: a period completed with no sig1 edge, so the sample is discarded.
timeout  out  1  one-cycle pulse: no sig0 edge within TIMEOUT cycles.
overrun  out  1  sticky flag: a result was dropped because out_valid was still high.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): all outputs 0, sums 0, synchronizers 0, FSM in S_ARM, sample count 0, accumulators 0.
- Input path, per channel: 2-FF synchronizer, then a previous-sample register. edge = sync & ~prev. Pin-to-edge latency is 3 cycles, identical on both channels, so the phase count is unaffected.
- S_ARM: wait for edge0. On edge0, go to S_MEAS with cnt=0 and seen1=0. If edge1 occurs in the same cycle, set seen1=1 and phase=0.
- S_MEAS: cnt increments by 1 each cycle.
  - First edge1: latch phase=cnt+1 and set seen1. Later edge1s in the same period are ignored.
  - Next edge0, with seen1=1: acc_phase += phase, acc_period += cnt+1, n++. Start a new measurement in the same cycle (cnt=0, seen1=0). An edge1 coincident with this edge0 belongs to the new measurement (phase=0).
  - Next edge0, with seen1=0: pulse err_miss, discard the sample, restart the measurement. n and the accumulators are unchanged.
  - cnt reaches TIMEOUT-1 without edge0: pulse timeout, clear n and the accumulators, go to S_ARM.
- Result: when n wraps to 0 after 2^NAVG_LOG2 accepted samples, the accumulators are copied to phase_sum/period_sum on the next cycle and out_valid=1. Accumulators are then cleared, and measurement continues without gaps.
- Handshake: out_valid stays high and the sums stay stable until a cycle with out_ready=1, after which out_valid=0 on the next cycle.
  - A new result arriving while out_valid=1 and out_ready=0: result dropped, overrun set to 1 until rst.
  - A new result coincident with an accepting cycle (out_ready=1): new result loaded, out_valid stays 1, no overrun.
- Widths: accumulators are CW+NAVG_LOG2 bits and cannot overflow, because each term is < 2^CW.
- rst mid-measurement or mid-handshake: immediate return to the reset state; any pending result is lost.

Optional Feature:
PHASE_PAIR_METER_DEGLITCH_EN
- Defined: each synchronized channel passes through a 3-sample majority filter before edge detection. Single-cycle glitches are rejected, and pin-to-edge latency becomes 5 cycles on both channels.
- Undefined: no filter, latency 3 cycles.

Decomposition:
- Package phase_pair_meter_pkg: FSM state encoding (S_ARM, S_MEAS), default CW/NAVG_LOG2/TIMEOUT constants, and the derived sum width CW+NAVG_LOG2.
- One sub-module, edge_sync: synchronizer plus optional majority filter plus rising-edge pulse. Instantiated once per channel.

Test Plan:
- sig0 period 100 cycles, sig1 same period lagging 25 cycles, 16 periods -> out_valid with phase_sum=400, period_sum=1600; overrun=0.
- sig1 tied low, sig0 period 100 -> err_miss pulse every 100 cycles, out_valid never asserts.
- sig0 stops for 65535 cycles -> single timeout pulse; the FSM rearms, and the next 16 good periods give a correct result.
- out_ready held 0 across two complete results -> first result held unchanged, overrun=1. Pulse out_ready -> out_valid falls on the next cycle.
- sig0 and sig1 edges coincident (lag 0), period 50 -> phase_sum=0, period_sum=800.
- DEGLITCH_EN build, 1-cycle glitch on sig1 mid-period at lag 10, true edge at lag 30 -> phase_sum=16*30=480. Without the macro -> phase_sum=160.

Source files
------------

// File: rtl/phase_pair_meter_pkg.sv
// Shared constants and FSM encoding for the dual-channel phase/period meter.
package phase_pair_meter_pkg;

    localparam int unsigned CW_DEF        = 16;
    localparam int unsigned NAVG_LOG2_DEF = 4;
    localparam int unsigned TIMEOUT_DEF   = 65535;
    localparam int unsigned SUM_W_DEF     = CW_DEF + NAVG_LOG2_DEF;

    typedef enum logic {
        S_ARM  = 1'b0,
        S_MEAS = 1'b1
    } state_t;

endpackage

// File: rtl/phase_pair_meter_edge_sync.sv
// Per-channel synchronizer and rising-edge detector.
// Optional 3-sample majority filter enabled by PHASE_PAIR_METER_DEGLITCH_EN.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise_c
);

    logic meta;
    logic sync;
    logic prev;

`ifdef PHASE_PAIR_METER_DEGLITCH_EN
    logic h1;
    logic h2;
    logic filt;
    logic maj;

    assign maj = (sync & h1) | (sync & h2) | (h1 & h2);

    // Majority filter adds two cycles; both channels see the same delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            h1   <= 1'b0;
            h2   <= 1'b0;
            filt <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
            h1   <= sync;
            h2   <= h1;
            filt <= maj;
            prev <= filt;
        end
    end

    assign rise_c = filt & ~prev;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise_c = sync & ~prev;
`endif

endmodule

// File: rtl/phase_pair_meter.sv
// Measures ch0->ch1 delay and ch0 period, sums 2^NAVG_LOG2 samples, valid/ready result.
// Build option: PHASE_PAIR_METER_DEGLITCH_EN (majority filter in edge_sync).
module phase_pair_meter
    import phase_pair_meter_pkg::*;
#(
    parameter int unsigned CW        = CW_DEF,
    parameter int unsigned NAVG_LOG2 = NAVG_LOG2_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sig0,
    input  logic                      sig1,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [CW+NAVG_LOG2-1:0]   phase_sum,
    output logic [CW+NAVG_LOG2-1:0]   period_sum,
    output logic                      err_miss,
    output logic                      timeout,
    output logic                      overrun
);

    localparam int unsigned SW = CW + NAVG_LOG2;
    localparam logic [NAVG_LOG2-1:0] N_LAST = '1;

    logic edge0;
    logic edge1;

    edge_sync u_sync0 (.clk(clk), .rst(rst), .pin(sig0), .rise_c(edge0));
    edge_sync u_sync1 (.clk(clk), .rst(rst), .pin(sig1), .rise_c(edge1));

    state_t                state,      state_nx;
    logic [CW-1:0]         cnt,        cnt_nx;
    logic [CW-1:0]         phase,      phase_nx;
    logic                  seen1,      seen1_nx;
    logic [NAVG_LOG2-1:0]  n,          n_nx;
    logic [SW-1:0]         acc_phase,  acc_phase_nx;
    logic [SW-1:0]         acc_period, acc_period_nx;
    logic                  out_valid_nx;
    logic [SW-1:0]         phase_sum_nx;
    logic [SW-1:0]         period_sum_nx;
    logic                  err_miss_nx;
    logic                  timeout_nx;
    logic                  overrun_nx;

    logic [CW-1:0]         cnt_inc;
    logic [SW-1:0]         res_phase;
    logic [SW-1:0]         res_period;
    logic                  res_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_ARM;
            cnt        <= '0;
            phase      <= '0;
            seen1      <= 1'b0;
            n          <= '0;
            acc_phase  <= '0;
            acc_period <= '0;
            out_valid  <= 1'b0;
            phase_sum  <= '0;
            period_sum <= '0;
            err_miss   <= 1'b0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            phase      <= phase_nx;
            seen1      <= seen1_nx;
            n          <= n_nx;
            acc_phase  <= acc_phase_nx;
            acc_period <= acc_period_nx;
            out_valid  <= out_valid_nx;
            phase_sum  <= phase_sum_nx;
            period_sum <= period_sum_nx;
            err_miss   <= err_miss_nx;
            timeout    <= timeout_nx;
            overrun    <= overrun_nx;
        end
    end

    assign cnt_inc    = cnt + CW'(1);
    assign res_phase  = acc_phase + SW'(phase);
    assign res_period = acc_period + SW'(cnt_inc);

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        phase_nx      = phase;
        seen1_nx      = seen1;
        n_nx          = n;
        acc_phase_nx  = acc_phase;
        acc_period_nx = acc_period;
        err_miss_nx   = 1'b0;
        timeout_nx    = 1'b0;
        res_load      = 1'b0;
        out_valid_nx  = out_valid;
        phase_sum_nx  = phase_sum;
        period_sum_nx = period_sum;
        overrun_nx    = overrun;

        case (state)
            S_ARM: begin
                if (edge0) begin
                    state_nx = S_MEAS;
                    cnt_nx   = '0;
                    seen1_nx = edge1;
                    phase_nx = '0;
                end
            end
            S_MEAS: begin
                if (edge0) begin
                    // A ch1 edge coincident with ch0 opens the next measurement at phase 0.
                    cnt_nx   = '0;
                    seen1_nx = edge1;
                    phase_nx = '0;
                    if (seen1) begin
                        n_nx = n + NAVG_LOG2'(1);
                        if (n == N_LAST) begin
                            res_load      = 1'b1;
                            acc_phase_nx  = '0;
                            acc_period_nx = '0;
                        end else begin
                            acc_phase_nx  = res_phase;
                            acc_period_nx = res_period;
                        end
                    end else begin
                        err_miss_nx = 1'b1;
                    end
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timeout_nx    = 1'b1;
                    n_nx          = '0;
                    acc_phase_nx  = '0;
                    acc_period_nx = '0;
                    state_nx      = S_ARM;
                end else begin
                    cnt_nx = cnt_inc;
                    if (edge1 && !seen1) begin
                        phase_nx = cnt_inc;
                        seen1_nx = 1'b1;
                    end
                end
            end
            default: state_nx = S_ARM;
        endcase

        // Output register: load on a free or accepting cycle, otherwise drop and flag.
        if (res_load) begin
            if (!out_valid || out_ready) begin
                out_valid_nx  = 1'b1;
                phase_sum_nx  = res_phase;
                period_sum_nx = res_period;
            end else begin
                overrun_nx = 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_phase_pair_meter.sv
// Scoreboard bench for phase_pair_meter: directed waveforms, queued expected sums.
module tb_phase_pair_meter;

    localparam int unsigned SW = 20;

`ifdef PHASE_PAIR_METER_DEGLITCH_EN
    localparam int GLITCH_PHASE = 480;
`else
    localparam int GLITCH_PHASE = 160;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          sig0;
    logic          sig1;
    logic          out_ready;
    logic          out_valid;
    logic [SW-1:0] phase_sum;
    logic [SW-1:0] period_sum;
    logic          err_miss;
    logic          timeout;
    logic          overrun;

    phase_pair_meter dut (
        .clk(clk), .rst(rst), .sig0(sig0), .sig1(sig1), .out_ready(out_ready),
        .out_valid(out_valid), .phase_sum(phase_sum), .period_sum(period_sum),
        .err_miss(err_miss), .timeout(timeout), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] ph;
        logic [SW-1:0] pe;
    } res_t;

    res_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_err_pulse = 0;
    int   n_to_pulse = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Pops and compares whenever a result is handed over; also counts pulses.
    task automatic monitor_loop();
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (err_miss) n_err_pulse++;
                if (timeout)  n_to_pulse++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got phase=%0d period=%0d, want none",
                                 phase_sum, period_sum);
                    end else begin
                        e = exp_q.pop_front();
                        check("phase_sum", longint'(phase_sum), longint'(e.ph));
                        check("period_sum", longint'(period_sum), longint'(e.pe));
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sig0 = 1'b0;
        sig1 = 1'b0;
        idle(3);
        rst = 1'b0;
        tick();
    endtask

    task automatic push(input int ph, input int pe);
        res_t r;
        r.ph = SW'(ph);
        r.pe = SW'(pe);
        exp_q.push_back(r);
    endtask

    // np periods of length per; ch1 high on [lag, lag+per/2) plus an optional single-cycle glitch.
    task automatic run(input int np, input int per, input int lag, input int glitch);
        for (int p = 0; p < np; p++) begin
            for (int c = 0; c < per; c++) begin
                sig0 = (c < per / 2);
                sig1 = ((c >= lag) && (c < lag + per / 2)) || (c == glitch);
                tick();
            end
        end
        sig0 = 1'b0;
        sig1 = 1'b0;
    endtask

    task automatic drain(input string name, input int max);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max) begin
            tick();
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d results pending, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int base;
        out_ready = 1'b1;
        rst  = 1'b1;
        sig0 = 1'b0;
        sig1 = 1'b0;
        fork
            monitor_loop();
        join_none

        do_reset();
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_phase_sum", longint'(phase_sum), 0);
        check("rst_period_sum", longint'(period_sum), 0);
        check("rst_overrun", longint'(overrun), 0);
        check("rst_err_miss", longint'(err_miss), 0);
        check("rst_timeout", longint'(timeout), 0);

        // Lag 25, period 100: 17 ch0 edges give 16 samples.
        base = n_err_pulse;
        push(400, 1600);
        run(17, 100, 25, -1);
        drain("lag25", 400);
        check("lag25_overrun", longint'(overrun), 0);
        check("lag25_err_miss_count", longint'(n_err_pulse - base), 0);

        // ch1 silent: every period after the first is discarded.
        do_reset();
        base = n_err_pulse;
        run(6, 100, 1000, -1);
        idle(10);
        check("miss_err_miss_count", longint'(n_err_pulse - base), 5);

        // ch0 stops: one timeout, then a clean result after rearming.
        do_reset();
        base = n_to_pulse;
        run(3, 100, 25, -1);
        idle(65600);
        check("timeout_count", longint'(n_to_pulse - base), 1);
        push(400, 1600);
        run(17, 100, 25, -1);
        drain("after_timeout", 400);

        // Consumer stalls across two results: first held, second dropped.
        do_reset();
        out_ready = 1'b0;
        push(400, 1600);
        run(17, 100, 25, -1);
        run(16, 100, 40, -1);
        idle(20);
        check("stall_out_valid", longint'(out_valid), 1);
        check("stall_overrun", longint'(overrun), 1);
        check("stall_phase_hold", longint'(phase_sum), 400);
        check("stall_period_hold", longint'(period_sum), 1600);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_valid_fall", longint'(out_valid), 0);
        drain("stall", 5);

        // Coincident edges, period 50.
        do_reset();
        out_ready = 1'b1;
        push(0, 800);
        run(17, 50, 0, -1);
        drain("lag0", 400);

        // Single-cycle ch1 glitch at 10, true edge at 30.
        do_reset();
        push(GLITCH_PHASE, 1600);
        run(17, 100, 30, 10);
        drain("glitch", 400);

        // Reset while a result is pending drops it.
        do_reset();
        out_ready = 1'b0;
        run(17, 100, 25, -1);
        idle(10);
        check("pend_out_valid", longint'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_phase_sum", longint'(phase_sum), 0);
        check("midrst_overrun", longint'(overrun), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
